// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types and constants for the QRAcc control path.
//   - qracc_trigger_t : trigger codes issued to the controller
//   - qracc_config_t  : layer configuration snapshot consumed by the controller
//   - CSR index and CSR0 bit-position constants used by qracc_csr
//   - pack_config()   : packs the staging words CSR1..CSR5 into qracc_config_t
package qracc_pkg;

  localparam int unsigned NUM_CSRS = 6;
  localparam int unsigned ADDR_LSB = 2;

  // Codes 6 and 7 are not defined and are rejected at the CSR.
  typedef enum logic [2:0] {
    TRIGGER_IDLE            = 3'd0,
    TRIGGER_LOAD_ACTIVATION = 3'd1,
    TRIGGER_LOAD_WEIGHTS    = 3'd2,
    TRIGGER_COMPUTE_ANALOG  = 3'd3,
    TRIGGER_COMPUTE_DIGITAL = 3'd4,
    TRIGGER_READ_ACTIVATION = 3'd5
  } qracc_trigger_t;

  localparam logic [2:0] TRIGGER_LAST_VALID = 3'd5;

  localparam logic [2:0] CSR_MAIN           = 3'd0;
  localparam logic [2:0] CSR_CONFIG         = 3'd1;
  localparam logic [2:0] CSR_IFMAP_DIMS     = 3'd2;
  localparam logic [2:0] CSR_OFMAP_DIMS     = 3'd3;
  localparam logic [2:0] CSR_CHANNELS       = 3'd4;
  localparam logic [2:0] CSR_MAPPED_OFFSETS = 3'd5;

  localparam int unsigned CSR0_TRIG_LSB  = 0;
  localparam int unsigned CSR0_TRIG_MSB  = 2;
  localparam int unsigned CSR0_CLEAR     = 3;
  localparam int unsigned CSR0_BUSY      = 4;
  localparam int unsigned CSR0_IWM       = 5;
  localparam int unsigned CSR0_DROPPED   = 6;
  localparam int unsigned CSR0_STATE_LSB = 8;
  localparam int unsigned CSR0_STATE_MSB = 11;

  // CSR1 bits [3:2] are reserved and never stored.
  localparam logic [31:0] CSR1_WMASK = 32'hFFFF_FFF3;

  typedef struct packed {
    logic        binary_cfg;
    logic        unsigned_acts;
    logic [3:0]  adc_ref_range_shifts;
    logic [3:0]  filter_size_y;
    logic [3:0]  filter_size_x;
    logic [3:0]  stride_x;
    logic [3:0]  stride_y;
    logic [3:0]  n_input_bits_cfg;
    logic [3:0]  n_output_bits_cfg;
    logic [15:0] input_fmap_dimx;
    logic [15:0] input_fmap_dimy;
    logic [15:0] output_fmap_dimx;
    logic [15:0] output_fmap_dimy;
    logic [15:0] num_input_channels;
    logic [15:0] num_output_channels;
    logic [15:0] mapped_matrix_offset_x;
    logic [15:0] mapped_matrix_offset_y;
  } qracc_config_t;

  function automatic qracc_config_t pack_config(
    input logic [31:0] c1,
    input logic [31:0] c2,
    input logic [31:0] c3,
    input logic [31:0] c4,
    input logic [31:0] c5
  );
    qracc_config_t c;
    logic          unused_rsvd;
    unused_rsvd              = ^c1[3:2];
    c.binary_cfg             = c1[0];
    c.unsigned_acts          = c1[1];
    c.adc_ref_range_shifts   = c1[7:4];
    c.filter_size_y          = c1[11:8];
    c.filter_size_x          = c1[15:12];
    c.stride_x               = c1[19:16];
    c.stride_y               = c1[23:20];
    c.n_input_bits_cfg       = c1[27:24];
    c.n_output_bits_cfg      = c1[31:28];
    c.input_fmap_dimx        = c2[15:0];
    c.input_fmap_dimy        = c2[31:16];
    c.output_fmap_dimx       = c3[15:0];
    c.output_fmap_dimy       = c3[31:16];
    c.num_input_channels     = c4[15:0];
    c.num_output_channels    = c4[31:16];
    c.mapped_matrix_offset_x = c5[15:0];
    c.mapped_matrix_offset_y = c5[31:16];
    return c;
  endfunction

endpackage

// File: rtl/qracc_ctrl_interface.sv
// qracc_ctrl_interface: host control bus, one word transfer per valid && ready.
//   data/addr/wen/valid : master -> slave
//   ready/read_data     : slave -> master
interface qracc_ctrl_interface;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wen;
  logic        valid;
  logic        ready;
  logic [31:0] read_data;

  modport slave  (input  data, addr, wen, valid, output ready, read_data);
  modport master (output data, addr, wen, valid, input  ready, read_data);
endinterface

// File: rtl/qracc_csr.sv
// qracc_csr: host-visible register bank in front of the QRAcc controller.
// Holds CSR0 (control/status) and the staging words CSR1..CSR5, snapshots the
// staging words into cfg_o when a trigger issues, and tracks controller busy.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   ctrl               : host bus slave (ready is registered, no backpressure)
//   done_i             : controller finished the current trigger
//   ctrl_state_i       : controller state, mirrored in CSR0[11:8]
//   cfg_o              : configuration snapshot taken at trigger issue
//   trigger_o          : trigger code, TRIGGER_IDLE outside the pulse
//   trigger_valid_o    : one-cycle strobe with trigger_o
//   clear_o            : one-cycle clear pulse
//   inst_write_mode_o  : level copy of CSR0[5]
//   busy_o             : trigger in flight
module qracc_csr
  import qracc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  qracc_ctrl_interface.slave  ctrl,
  input  logic                done_i,
  input  logic [3:0]          ctrl_state_i,
  output qracc_config_t       cfg_o,
  output qracc_trigger_t      trigger_o,
  output logic                trigger_valid_o,
  output logic                clear_o,
  output logic                inst_write_mode_o,
  output logic                busy_o
);

  logic                      ready_q;
  logic [NUM_CSRS-1:1][31:0] stage_q, stage_d;
  logic                      iwm_q, iwm_d;
  logic                      dropped_q, dropped_d;
  logic [2:0]                last_trig_q, last_trig_d;
  logic                      busy_q, busy_d;
  qracc_config_t             cfg_q, cfg_d;
  qracc_trigger_t            trig_q, trig_d;
  logic                      trig_valid_q, trig_valid_d;
  logic                      clear_q, clear_d;
  logic [31:0]               read_data_q, read_data_d;

  logic        accept, wr_en, rd_en;
  logic [2:0]  csr_idx;
  logic [2:0]  wr_code;
  logic [31:0] csr0_val, rd_val;
  logic        unused_addr;

  assign accept      = ctrl.valid && ready_q;
  assign wr_en       = accept && ctrl.wen;
  assign rd_en       = accept && !ctrl.wen;
  assign csr_idx     = ctrl.addr[ADDR_LSB+2:ADDR_LSB];
  assign wr_code     = ctrl.data[CSR0_TRIG_MSB:CSR0_TRIG_LSB];
  assign unused_addr = ^{ctrl.addr[31:ADDR_LSB+3], ctrl.addr[ADDR_LSB-1:0]};

  always_comb begin
    csr0_val = '0;
    csr0_val[CSR0_TRIG_MSB:CSR0_TRIG_LSB]   = last_trig_q;
    csr0_val[CSR0_BUSY]                     = busy_q;
    csr0_val[CSR0_IWM]                      = iwm_q;
    csr0_val[CSR0_DROPPED]                  = dropped_q;
    csr0_val[CSR0_STATE_MSB:CSR0_STATE_LSB] = ctrl_state_i;

    case (csr_idx)
      CSR_MAIN:           rd_val = csr0_val;
      CSR_CONFIG:         rd_val = stage_q[CSR_CONFIG];
      CSR_IFMAP_DIMS:     rd_val = stage_q[CSR_IFMAP_DIMS];
      CSR_OFMAP_DIMS:     rd_val = stage_q[CSR_OFMAP_DIMS];
      CSR_CHANNELS:       rd_val = stage_q[CSR_CHANNELS];
      CSR_MAPPED_OFFSETS: rd_val = stage_q[CSR_MAPPED_OFFSETS];
      default:            rd_val = '0;
    endcase
  end

  always_comb begin
    stage_d      = stage_q;
    iwm_d        = iwm_q;
    dropped_d    = dropped_q;
    last_trig_d  = last_trig_q;
    cfg_d        = cfg_q;
    trig_d       = TRIGGER_IDLE;
    trig_valid_d = 1'b0;
    clear_d      = 1'b0;
    read_data_d  = rd_en ? rd_val : read_data_q;
    // done is applied before any trigger in the same cycle, so a trigger
    // arriving with done sees the controller as free.
    busy_d       = busy_q && !done_i;

    if (wr_en) begin
      case (csr_idx)
        CSR_MAIN: begin
          iwm_d = ctrl.data[CSR0_IWM];
          if (ctrl.data[CSR0_DROPPED]) dropped_d = 1'b0;
          if (ctrl.data[CSR0_CLEAR]) begin
            clear_d = 1'b1;
            busy_d  = 1'b0;
          end else if (wr_code != TRIGGER_IDLE) begin
            // A new drop in the same write wins over the W1C of the flag.
            if (wr_code > TRIGGER_LAST_VALID || busy_d) begin
              dropped_d = 1'b1;
            end else begin
              trig_d       = qracc_trigger_t'(wr_code);
              trig_valid_d = 1'b1;
              last_trig_d  = wr_code;
              busy_d       = 1'b1;
              cfg_d        = pack_config(stage_q[CSR_CONFIG], stage_q[CSR_IFMAP_DIMS],
                                         stage_q[CSR_OFMAP_DIMS], stage_q[CSR_CHANNELS],
                                         stage_q[CSR_MAPPED_OFFSETS]);
            end
          end
        end
        CSR_CONFIG:         stage_d[CSR_CONFIG]         = ctrl.data & CSR1_WMASK;
        CSR_IFMAP_DIMS:     stage_d[CSR_IFMAP_DIMS]     = ctrl.data;
        CSR_OFMAP_DIMS:     stage_d[CSR_OFMAP_DIMS]     = ctrl.data;
        CSR_CHANNELS:       stage_d[CSR_CHANNELS]       = ctrl.data;
        CSR_MAPPED_OFFSETS: stage_d[CSR_MAPPED_OFFSETS] = ctrl.data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q      <= 1'b0;
      stage_q      <= '0;
      iwm_q        <= 1'b0;
      dropped_q    <= 1'b0;
      last_trig_q  <= '0;
      busy_q       <= 1'b0;
      cfg_q        <= '0;
      trig_q       <= TRIGGER_IDLE;
      trig_valid_q <= 1'b0;
      clear_q      <= 1'b0;
      read_data_q  <= '0;
    end else begin
      ready_q      <= 1'b1;
      stage_q      <= stage_d;
      iwm_q        <= iwm_d;
      dropped_q    <= dropped_d;
      last_trig_q  <= last_trig_d;
      busy_q       <= busy_d;
      cfg_q        <= cfg_d;
      trig_q       <= trig_d;
      trig_valid_q <= trig_valid_d;
      clear_q      <= clear_d;
      read_data_q  <= read_data_d;
    end
  end

  assign ctrl.ready        = ready_q;
  assign ctrl.read_data    = read_data_q;
  assign cfg_o             = cfg_q;
  assign trigger_o         = trig_q;
  assign trigger_valid_o   = trig_valid_q;
  assign clear_o           = clear_q;
  assign inst_write_mode_o = iwm_q;
  assign busy_o            = busy_q;

endmodule
